// File: rtl/pcpu_if_pkg.sv
// Shared IF-stage definitions: fetch FSM encoding, PC increment and default reset/NOP values.
package pcpu_if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_st_e;

  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: PC owner, single-outstanding imem req/gnt/rvalid fetch, IF/ID presentation.
// Latency: IF_valid two cycles after imem_req when gnt is immediate and rvalid follows; stalls hold HOLD.
module if_fetch_unit
  import pcpu_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IF_IDWrite,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_inst,
  output logic [31:0] PC_out,
  output logic        IF_valid
);

  fetch_st_e   st_q, st_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic        kill_q, kill_d;
  logic [31:0] tgt;

  assign tgt = redirect_pc & WORD_MASK;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= FETCH;
      pc_q   <= RESET_PC;
      kill_q <= 1'b0;
      buf_q  <= NOP_INST;
    end else begin
      st_q   <= st_d;
      pc_q   <= pc_d;
      kill_q <= kill_d;
      buf_q  <= buf_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    pc_d   = pc_q;
    kill_d = kill_q;
    buf_d  = buf_q;
    case (st_q)
      FETCH: begin
        // The address may move while ungranted; a grant on the old address is killed.
        if (redirect_valid) pc_d = tgt;
        if (imem_gnt) begin
          st_d = WAIT;
          if (redirect_valid) kill_d = 1'b1;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d = tgt;
          if (imem_rvalid) begin
            kill_d = 1'b0;
            st_d   = FETCH;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill_q) begin
            kill_d = 1'b0;
            st_d   = FETCH;
          end else begin
            buf_d = imem_rdata;
            st_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d = tgt;
          st_d = FETCH;
        end else if (IF_IDWrite) begin
          pc_d = pc_q + PC_STEP;
          st_d = FETCH;
        end
      end
      default: st_d = FETCH;
    endcase
  end

  assign imem_req  = reset && (st_q == FETCH);
  assign imem_addr = pc_q;
  assign PC_out    = pc_q;
  assign IF_valid  = (st_q == HOLD);
  assign IF_inst   = (st_q == HOLD) ? buf_q : NOP_INST;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed cycle table, reset-in-WAIT sequence, random run vs. program-order model.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, IF_IDWrite, redirect_valid, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, IF_valid;
  logic [31:0] imem_addr, IF_inst, PC_out;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .IF_IDWrite(IF_IDWrite),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_inst(IF_inst), .PC_out(PC_out), .IF_valid(IF_valid)
  );

  typedef struct {
    logic        rst, wr, rv;
    logic [31:0] rpc;
    logic        gnt, rvl;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evld;
    logic [31:0] einst;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add(input logic rst, wr, rv, input logic [31:0] rpc, input logic gnt, rvl,
                     input logic [31:0] rdata, input logic ereq, input logic [31:0] eaddr,
                     input logic evld, input logic [31:0] einst);
    vecs.push_back('{rst, wr, rv, rpc, gnt, rvl, rdata, ereq, eaddr, evld, einst});
  endtask

  task automatic drive(input logic rst, wr, rv, input logic [31:0] rpc, input logic gnt, rvl,
                       input logic [31:0] rdata);
    reset = rst; IF_IDWrite = wr; redirect_valid = rv; redirect_pc = rpc;
    imem_gnt = gnt; imem_rvalid = rvl; imem_rdata = rdata;
  endtask

  task automatic expect_out(input string nm, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] inst);
    chk({nm, ".req"},  imem_req,  req);
    chk({nm, ".addr"}, imem_addr, addr);
    chk({nm, ".pc"},   PC_out,    addr);
    chk({nm, ".vld"},  IF_valid,  vld);
    chk({nm, ".inst"}, IF_inst,   inst);
  endtask

  // Distinct word per address so a wrong-address or stale fetch is visible in IF_inst.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[18:0], a[31:19]} ^ 32'h9E37_79B9;
  endfunction

  bit          pend;
  logic [31:0] pend_addr, exp_pc, gaddr;
  int          pend_cnt, accepted;
  logic        granted, acc;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);

    //   rst wr rv rpc            gnt rvl rdata          | req addr           vld inst
    add(0, 0, 0, 32'h0,          0, 0, 32'h0,           0, 32'h0000_3000, 0, NOP);
    add(1, 1, 0, 32'h0,          1, 0, 32'h0,           1, 32'h0000_3000, 0, NOP);
    add(1, 1, 0, 32'h0,          0, 1, 32'h2408_0005,   0, 32'h0000_3000, 0, NOP);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,           0, 32'h0000_3000, 1, 32'h2408_0005);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,           1, 32'h0000_3004, 0, NOP);
    add(1, 1, 0, 32'h0,          1, 0, 32'h0,           1, 32'h0000_3004, 0, NOP);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,           0, 32'h0000_3004, 0, NOP);
    add(1, 1, 0, 32'h0,          0, 1, 32'h1111_1111,   0, 32'h0000_3004, 0, NOP);
    for (int k = 0; k < 4; k++)
      add(1, 0, 0, 32'h0,        0, 0, 32'h0,           0, 32'h0000_3004, 1, 32'h1111_1111);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,           0, 32'h0000_3004, 1, 32'h1111_1111);
    add(1, 1, 0, 32'h0,          1, 0, 32'h0,           1, 32'h0000_3008, 0, NOP);
    add(1, 1, 0, 32'h0,          0, 1, 32'h2222_2222,   0, 32'h0000_3008, 0, NOP);
    add(1, 1, 1, 32'h0000_3103,  0, 0, 32'h0,           0, 32'h0000_3008, 1, 32'h2222_2222);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,           1, 32'h0000_3100, 0, NOP);
    add(1, 1, 1, 32'h0000_3200,  1, 0, 32'h0,           1, 32'h0000_3100, 0, NOP);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,           0, 32'h0000_3200, 0, NOP);
    add(1, 1, 0, 32'h0,          0, 1, 32'hDEAD_BEEF,   0, 32'h0000_3200, 0, NOP);
    add(1, 1, 0, 32'h0,          1, 0, 32'h0,           1, 32'h0000_3200, 0, NOP);
    add(1, 1, 1, 32'h0000_3100,  0, 0, 32'h0,           0, 32'h0000_3200, 0, NOP);
    add(1, 1, 0, 32'h0,          0, 1, 32'hDEAD_BEEF,   0, 32'h0000_3100, 0, NOP);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,           1, 32'h0000_3100, 0, NOP);
    add(1, 1, 0, 32'h0,          1, 0, 32'h0,           1, 32'h0000_3100, 0, NOP);
    add(1, 1, 1, 32'h0000_5000,  0, 1, 32'h3333_3333,   0, 32'h0000_3100, 0, NOP);
    add(1, 1, 1, 32'hFFFF_FFFE,  1, 0, 32'h0,           1, 32'h0000_5000, 0, NOP);
    add(1, 1, 0, 32'h0,          0, 1, 32'h4444_4444,   0, 32'hFFFF_FFFC, 0, NOP);
    add(1, 1, 0, 32'h0,          1, 0, 32'h0,           1, 32'hFFFF_FFFC, 0, NOP);
    add(1, 1, 0, 32'h0,          0, 1, 32'h5555_5555,   0, 32'hFFFF_FFFC, 0, NOP);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,           0, 32'hFFFF_FFFC, 1, 32'h5555_5555);
    add(1, 1, 0, 32'h0,          0, 0, 32'h0,           1, 32'h0000_0000, 0, NOP);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].rv, vecs[i].rpc, vecs[i].gnt, vecs[i].rvl, vecs[i].rdata);
      @(negedge clk);
      expect_out($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].eaddr, vecs[i].evld, vecs[i].einst);
      @(posedge clk); #1;
    end

    // Reset lands while a response is outstanding; a redirect during reset must be ignored.
    drive(1, 1, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    drive(0, 1, 1, 32'h0000_7000, 0, 0, 0);
    @(negedge clk); expect_out("rstwait0", 0, RST_PC, 0, NOP);
    @(posedge clk); #1;
    @(negedge clk); expect_out("rstwait1", 0, RST_PC, 0, NOP);
    @(posedge clk); #1;
    drive(1, 1, 0, 0, 0, 0, 0);
    @(negedge clk); expect_out("rstrel", 1, RST_PC, 0, NOP);
    @(posedge clk); #1;
    drive(1, 1, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    drive(1, 1, 0, 0, 0, 1, 32'h6666_6666);
    @(negedge clk); expect_out("rstwait_resp", 0, RST_PC, 0, NOP);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk); expect_out("rsthold", 0, RST_PC, 1, 32'h6666_6666);

    // Random run: the model only tracks which PC program order says comes next.
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    pend = 0; exp_pc = RST_PC; accepted = 0; pend_cnt = 0; pend_addr = 0;
    for (int c = 0; c < 3000; c++) begin
      IF_IDWrite     = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      imem_gnt       = !pend && ($urandom_range(0, 9) < 7);
      if (pend && pend_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend) pend_cnt--;
      end
      @(negedge clk);
      if (imem_req) chk("rnd.align", {30'd0, imem_addr[1:0]}, 32'd0);
      if (pend) chk("rnd.single_outstanding", imem_req, 1'b0);
      if (IF_valid) begin
        chk($sformatf("rnd%0d.pc", c), PC_out, exp_pc);
        chk($sformatf("rnd%0d.inst", c), IF_inst, mem_word(exp_pc));
      end else begin
        chk($sformatf("rnd%0d.nop", c), IF_inst, NOP);
      end
      granted = imem_req && imem_gnt;
      gaddr   = imem_addr;
      acc     = IF_valid && IF_IDWrite && !redirect_valid;
      @(posedge clk); #1;
      if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      else if (acc) begin
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
      if (imem_rvalid) pend = 0;
      if (granted) begin
        pend      = 1;
        pend_addr = gaddr;
        pend_cnt  = $urandom_range(0, 2);
      end
    end
    chk("rnd.progress", 32'(accepted >= 100), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
